// File: rtl/led_trail_pkg.sv
// Shared constants and per-channel level-update decision for led_trail.
package led_trail_pkg;
`include "led_defs.vh"

  localparam int          DEF_CHANNELS   = `LED_CHANNELS;
  localparam int          DEF_PWM_BITS   = `LED_PWM_BITS;
  localparam logic [19:0] DEF_DECAY_DIV  = 20'd50000;
  localparam logic [7:0]  DEF_DECAY_STEP = 8'd16;

  // What a channel level does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_DECAY,
    ACT_CLEAR
  } lvl_act_e;

  // Disable clears; a lit input beats a coincident decay tick.
  function automatic lvl_act_e pick_act(input logic enable,
                                        input logic led_in,
                                        input logic decay_tick);
    lvl_act_e act;
    act = ACT_HOLD;
    if (!enable)         act = ACT_CLEAR;
    else if (led_in)     act = ACT_LOAD;
    else if (decay_tick) act = ACT_DECAY;
    return act;
  endfunction

endpackage

// File: rtl/led_defs.vh
// Default LED channel count and PWM resolution, shared by the run-LED
// counter and by led_trail so both sides agree on the bus width.
`ifndef LED_DEFS_VH
`define LED_DEFS_VH
`define LED_CHANNELS 10
`define LED_PWM_BITS 8
`endif

// File: rtl/led_trail_channel.sv
// One LED channel: brightness level with saturating decay, and the PWM
// compare that drives the registered LED output.
module led_trail_channel
  import led_trail_pkg::*;
#(
  parameter int         PWM_BITS   = DEF_PWM_BITS,
  parameter logic [7:0] DECAY_STEP = DEF_DECAY_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                led_in,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int                  WW  = PWM_BITS + 8;

  // Level minus DECAY_STEP, floored at zero; widened so a step larger
  // than the level can never wrap.
  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] lvl);
    logic [WW-1:0] wide;
    logic [WW-1:0] step;
    logic [WW-1:0] diff;
    wide = {8'd0, lvl};
    step = {{PWM_BITS{1'b0}}, DECAY_STEP};
    if (wide > step) diff = wide - step;
    else             diff = '0;
    return diff[PWM_BITS-1:0];
  endfunction

  logic [PWM_BITS-1:0] level_p0;
  logic                out_p1;
  logic [PWM_BITS-1:0] level_nxt;
  logic                out_nxt;
  lvl_act_e            act;

  assign level   = level_p0;
  assign led_out = out_p1;

  // Next level from the input/tick/enable decision; output compares the current level.
  always_comb begin
    act       = pick_act(enable, led_in, decay_tick);
    level_nxt = level_p0;
    case (act)
      ACT_CLEAR: level_nxt = '0;
      ACT_LOAD:  level_nxt = MAX;
      ACT_DECAY: level_nxt = sat_dec(level_p0);
      default:   level_nxt = level_p0;
    endcase
    out_nxt = enable && ((level_p0 == MAX) || (level_p0 > pwm_cnt));
  end

  // Stage p0: level register; stage p1: LED drive one cycle behind level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_p0 <= '0;
      out_p1   <= 1'b0;
    end else begin
      level_p0 <= level_nxt;
      out_p1   <= out_nxt;
    end
  end

endmodule

// File: rtl/led_trail.sv
// LED trail dimmer: each lit input channel jumps to full brightness and
// then fades out in DECAY_STEP steps, rendered through a shared PWM counter.
module led_trail
  import led_trail_pkg::*;
#(
  parameter int          CHANNELS   = DEF_CHANNELS,
  parameter int          PWM_BITS   = DEF_PWM_BITS,
  parameter logic [19:0] DECAY_DIV  = DEF_DECAY_DIV,
  parameter logic [7:0]  DECAY_STEP = DEF_DECAY_STEP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] led_in,
  input  logic                enable,
  output logic [CHANNELS-1:0] led_out,
  output logic                busy
);

  logic [19:0]         presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                decay_tick;
  logic [PWM_BITS-1:0] level [CHANNELS];

  assign decay_tick = enable && (presc == DECAY_DIV - 20'd1);

  // Decay prescaler: counts 0..DECAY_DIV-1, cleared while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           presc <= '0;
    else if (!enable)    presc <= '0;
    else if (decay_tick) presc <= '0;
    else                 presc <= presc + 20'd1;
  end

  // Free-running PWM ramp shared by all channels, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pwm_cnt <= '0;
    else if (!enable) pwm_cnt <= '0;
    else              pwm_cnt <= pwm_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    led_trail_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .led_in     (led_in[gi]),
      .decay_tick (decay_tick),
      .pwm_cnt    (pwm_cnt),
      .level      (level[gi]),
      .led_out    (led_out[gi])
    );
  end

  // Busy while any level register is nonzero.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CHANNELS; i++) busy = busy | (level[i] != '0);
  end

endmodule
